// File: rtl/psum_out_collector_if.sv
// Bundle between the MAC array south edge and the partial-sum collector.
// master = array/consumer side driving writes and pops, slave = the collector.
interface psum_out_collector_if #(
    parameter int col     = 8,
    parameter int psum_bw = 16
);
    logic [psum_bw*col-1:0] in_s;
    logic [col-1:0]         in_s_zero;
    logic [col-1:0]         valid;
    logic                   rd;
    logic                   o_full;
    logic                   o_ready;
    logic                   o_overflow;
    logic [psum_bw*col-1:0] out;
    logic [col-1:0]         out_zero;
    logic                   out_valid;

    modport master (
        output in_s, in_s_zero, valid, rd,
        input  o_full, o_ready, o_overflow, out, out_zero, out_valid
    );

    modport slave (
        input  in_s, in_s_zero, valid, rd,
        output o_full, o_ready, o_overflow, out, out_zero, out_valid
    );
endinterface

// File: rtl/psum_out_collector.sv
// Per-column FIFOs that de-skew the array's south outputs and release
// whole rows through a registered, pipelined readout.
module psum_out_collector #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int depth   = 16
) (
    input logic                  clk,
    input logic                  reset,
    psum_out_collector_if.slave  bus
);
    localparam int aw = $clog2(depth);

    typedef logic [aw:0] ptr_t;

    ptr_t                 wptr [col];
    ptr_t                 rptr [col];
    logic [psum_bw:0]     mem  [col][depth];
    logic [psum_bw:0]     head [col];

    logic [col-1:0]       empty;
    logic [col-1:0]       full;
    logic [col-1:0]       wr_en;
    logic [col-1:0]       drop;
    logic                 pop;

    logic [psum_bw*col-1:0] out_r;
    logic [col-1:0]         out_zero_r;
    logic                   out_valid_r;
    logic                   overflow_r;

    always_comb begin
        empty = '0;
        full  = '0;
        for (int i = 0; i < col; i++) begin
            empty[i] = (wptr[i] == rptr[i]);
            full[i]  = (wptr[i][aw-1:0] == rptr[i][aw-1:0]) &&
                       (wptr[i][aw] != rptr[i][aw]);
            head[i]  = mem[i][rptr[i][aw-1:0]];
        end
    end

    assign bus.o_ready = &(~empty);
    assign bus.o_full  = |full;
    assign pop         = bus.rd & bus.o_ready;

    // A full column may still take a write when the same cycle pops a row.
    always_comb begin
        wr_en = '0;
        drop  = '0;
        for (int i = 0; i < col; i++) begin
            wr_en[i] = bus.valid[i] & (~full[i] | pop);
            drop[i]  = bus.valid[i] & full[i] & ~pop;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < col; i++) begin
                wptr[i] <= '0;
                rptr[i] <= '0;
            end
            overflow_r <= 1'b0;
        end else begin
            for (int i = 0; i < col; i++) begin
                if (wr_en[i])
                    wptr[i] <= wptr[i] + 1'b1;
                if (pop)
                    rptr[i] <= rptr[i] + 1'b1;
            end
            if (|drop)
                overflow_r <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < col; i++) begin
            if (wr_en[i])
                mem[i][wptr[i][aw-1:0]] <= {bus.in_s_zero[i], bus.in_s[psum_bw*i +: psum_bw]};
        end
    end

    // Zero-flagged columns are forced to 0 so downstream never sees stale data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_r       <= '0;
            out_zero_r  <= '0;
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= pop;
            if (pop) begin
                for (int i = 0; i < col; i++) begin
                    out_zero_r[i]               <= head[i][psum_bw];
                    out_r[psum_bw*i +: psum_bw] <= head[i][psum_bw] ? '0 : head[i][psum_bw-1:0];
                end
            end
        end
    end

    assign bus.out        = out_r;
    assign bus.out_zero   = out_zero_r;
    assign bus.out_valid  = out_valid_r;
    assign bus.o_overflow = overflow_r;
endmodule

// File: tb/tb_psum_out_collector.sv
// Scoreboard bench: per-column queue model predicts rows on each accepted pop,
// a negedge monitor compares every out_valid strobe against the predictions.
module tb_psum_out_collector;
    localparam int COL   = 8;
    localparam int BW    = 16;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    psum_out_collector_if #(.col(COL), .psum_bw(BW)) bus ();

    psum_out_collector #(.col(COL), .psum_bw(BW), .depth(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [BW:0]        mq [COL][$];
    logic [BW*COL-1:0]  exp_out_q [$];
    logic [COL-1:0]     exp_zero_q [$];
    bit                 m_ovf = 1'b0;
    int                 n_chk = 0;
    int                 n_fail = 0;
    int                 n_strobe = 0;
    logic [BW-1:0]      rows [40][COL];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic bit m_ready();
        for (int i = 0; i < COL; i++)
            if (mq[i].size() == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit m_full();
        for (int i = 0; i < COL; i++)
            if (mq[i].size() == DEPTH) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < COL; i++) mq[i].delete();
        exp_out_q.delete();
        exp_zero_q.delete();
        m_ovf = 1'b0;
    endtask

    // One clock of stimulus: check status against the model, apply inputs, advance the model.
    task automatic drive(input logic [COL-1:0] v, input logic [COL-1:0] z,
                         input logic [BW*COL-1:0] d, input logic r);
        bit                pop;
        logic [BW*COL-1:0] row;
        logic [COL-1:0]    zr;
        logic [BW:0]       e;
        @(negedge clk); #1;
        chk("o_ready", {127'd0, bus.o_ready}, {127'd0, m_ready()});
        chk("o_full", {127'd0, bus.o_full}, {127'd0, m_full()});
        chk("o_overflow", {127'd0, bus.o_overflow}, {127'd0, m_ovf});
        bus.valid = v;
        bus.in_s_zero = z;
        bus.in_s = d;
        bus.rd = r;
        pop = r && m_ready();
        if (pop) begin
            row = '0;
            zr = '0;
            for (int i = 0; i < COL; i++) begin
                e = mq[i].pop_front();
                zr[i] = e[BW];
                row[i*BW +: BW] = e[BW] ? '0 : e[BW-1:0];
            end
            exp_out_q.push_back(row);
            exp_zero_q.push_back(zr);
        end
        for (int i = 0; i < COL; i++) begin
            if (v[i]) begin
                if (mq[i].size() < DEPTH) mq[i].push_back({z[i], d[i*BW +: BW]});
                else m_ovf = 1'b1;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        reset = 1'b1;
        bus.valid = '0;
        bus.rd = 1'b0;
        model_clear();
        @(negedge clk); #1;
        reset = 1'b0;
    endtask

    function automatic logic [BW*COL-1:0] rand_row();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    always @(negedge clk) begin
        if (bus.out_valid) begin
            n_strobe++;
            if (exp_out_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_strobe: got out_valid=1 expected 0 at %0t", $time);
            end else begin
                chk("out_row", bus.out, exp_out_q.pop_front());
                chk("out_zero", {120'd0, bus.out_zero}, {120'd0, exp_zero_q.pop_front()});
            end
        end else if (exp_out_q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL missing_strobe: got out_valid=0 expected 1 at %0t", $time);
            void'(exp_out_q.pop_front());
            void'(exp_zero_q.pop_front());
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [BW*COL-1:0] d;
        bus.valid = '0;
        bus.in_s_zero = '0;
        bus.in_s = '0;
        bus.rd = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out", bus.out, '0);
        chk("rst_out_zero", {120'd0, bus.out_zero}, '0);
        chk("rst_out_valid", {127'd0, bus.out_valid}, '0);
        chk("rst_ready", {127'd0, bus.o_ready}, '0);
        chk("rst_full", {127'd0, bus.o_full}, '0);
        @(negedge clk);
        reset = 1'b0;

        // single skewed row
        for (int i = 0; i < COL; i++) d[i*BW +: BW] = BW'(16'h1000 + i);
        for (int t = 0; t < COL; t++) drive(8'(1 << t), '0, d, 1'b0);
        drive('0, '0, '0, 1'b1);
        drive('0, '0, '0, 1'b0);
        drive('0, '0, '0, 1'b0);

        // fill, overflow on one column, drain
        for (int k = 0; k < DEPTH; k++) drive('1, 8'($urandom), rand_row(), 1'b0);
        drive(8'h08, '0, rand_row(), 1'b0);
        for (int k = 0; k < DEPTH + 1; k++) drive('0, '0, '0, 1'b1);
        drive('0, '0, '0, 1'b0);
        do_reset();

        // full with simultaneous push and pop
        for (int k = 0; k < DEPTH; k++) drive('1, '0, rand_row(), 1'b0);
        drive('1, 8'($urandom), rand_row(), 1'b1);
        for (int k = 0; k < DEPTH; k++) drive('0, '0, '0, 1'b1);
        drive('0, '0, '0, 1'b0);

        // zero flags
        drive('1, 8'hA5, '1, 1'b0);
        drive('0, '0, '0, 1'b1);
        drive('0, '0, '0, 1'b0);

        // 40 skewed rows streamed with continuous rd, wraps pointers
        for (int k = 0; k < 40; k++)
            for (int i = 0; i < COL; i++) rows[k][i] = BW'($urandom);
        for (int t = 0; t < 40 + COL + 2; t++) begin
            logic [COL-1:0] v;
            v = '0;
            d = '0;
            for (int i = 0; i < COL; i++) begin
                if (t - i >= 0 && t - i < 40) begin
                    v[i] = 1'b1;
                    d[i*BW +: BW] = rows[t-i][i];
                end
            end
            drive(v, 8'($urandom), d, 1'b1);
        end
        drive('0, '0, '0, 1'b0);

        // random traffic
        for (int t = 0; t < 400; t++)
            drive(8'($urandom), 8'($urandom), rand_row(), ($urandom_range(0, 2) != 0));
        for (int k = 0; k < DEPTH + 2; k++) drive('0, '0, '0, 1'b1);
        do_reset();

        // reset asserted mid-flush
        for (int k = 0; k < 5; k++) drive('1, '0, rand_row(), 1'b0);
        drive('0, '0, '0, 1'b1);
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        chk("midrst_out_valid", {127'd0, bus.out_valid}, '0);
        chk("midrst_ready", {127'd0, bus.o_ready}, '0);
        chk("midrst_out", bus.out, '0);
        model_clear();
        repeat (2) @(negedge clk);
        #1;
        reset = 1'b0;
        for (int k = 0; k < 6; k++) drive('0, '0, '0, 1'b1);
        drive('0, '0, '0, 1'b0);

        repeat (2) @(negedge clk);
        #1;
        chk("queue_drained", 128'(exp_out_q.size()), '0);
        chk("strobe_count_nonzero", {127'd0, (n_strobe > 70)}, 128'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/psum_out_collector.md
# psum_out_collector

- Sits on the south edge of the MAC array and captures the partial sums that each column emits when its `valid` bit rises.
- Holds one FIFO per column. Column i fires one cycle after column i-1 because instructions propagate west to east; the per-column FIFOs absorb that skew.
- A full output row is presented only once every column holds at least one entry.
- Readout is a registered, pipelined flush, so the array can keep executing while earlier results drain.

## Interface

Parameters:
- `col`, 8, number of array columns (one FIFO each).
- `psum_bw`, 16, partial-sum width per column.
- `depth`, 16, entries per column FIFO; power of two, at least 2.

Ports:
- `clk`  in  1  single clock; all state is updated on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `in_s`  in  psum_bw*col  per-column partial sums from the array's south outputs. Column i occupies bits [psum_bw*(i+1)-1 : psum_bw*i].
- `in_s_zero`  in  col  per-column flag meaning "psum known zero"; captured alongside the data.
- `valid`  in  col  per-column write strobe from the array.
- `rd`  in  1  pop request for one full row.
- `o_full`  out  1  asserted when any column FIFO is full.
- `o_ready`  out  1  asserted when every column FIFO is non-empty, meaning a row is poppable.
- `o_overflow`  out  1  sticky; set when a write is dropped.
- `out`  out  psum_bw*col  registered output row.
- `out_zero`  out  col  registered zero flags for the output row.
- `out_valid`  out  1  one-cycle strobe marking a new row on `out` / `out_zero`.

## Operation

Storage:
- Each column has its own `depth` x (psum_bw+1) storage array, holding data plus the zero flag.
- Each column has its own write pointer and read pointer, each log2(depth)+1 bits wide (includes a wrap bit).
- Empty: pointers are fully equal.
- Full: low bits are equal and wrap bits differ.
- Pointers wrap modulo 2*depth without special handling.

Writes (per column, independent):
- Column i writes `{in_s_zero[i], in_s[i]}` at its write pointer when `valid[i]` is high and the column can accept.
- A column can accept when it is not full, or when it is full and a pop is accepted in the same cycle.
- If `valid[i]` is high and the column cannot accept, the write is dropped, `o_overflow` is set, and the pointers are unchanged.

Reads:
- A pop is accepted when `rd` is high and `o_ready` is high. All col read pointers then advance together.
- On an accepted pop, the head entries are registered onto `out` / `out_zero` and `out_valid` is 1 in the next cycle.
- When `out_zero[i]` = 1, `out` column i is driven to 0 regardless of the stored data.
- `rd` while `o_ready` is low has no effect: `out_valid` stays 0 and `out` / `out_zero` hold their last value.

Status:
- `o_full` and `o_ready` are combinational from the pointers.
- `o_overflow` is cleared only by `reset`.

Simultaneous events:
- A push and a pop on the same column in the same cycle are both performed; the occupancy of that column is unchanged.
- A push into an empty column is not poppable in the same cycle (no fall-through); it becomes visible through `o_ready` in the next cycle.

Reset:
- All pointers are cleared and every FIFO is empty.
- `out`, `out_zero`, `out_valid` and `o_overflow` are 0.
- `o_full` is 0 and `o_ready` is 0.
- Reset asserted mid-flush discards all buffered rows; any in-flight `out_valid` is killed.

## Timing

- Write-to-ready latency: 1 cycle after the last column's write.
- Read latency: rd accepted at edge t, so `out` / `out_zero` / `out_valid` update at edge t+1.
- Back-to-back rd drains one row per cycle, with `out_valid` held high continuously.
- `out_valid` is high for exactly the cycle following each accepted pop.
- Skewed writes: with column i written in cycle t+i, `o_ready` rises in cycle t+col (after column col-1's write at t+col-1).

## Test plan

- Single skewed row: after reset, `valid[i]` = 1 for column i in cycle i with `in_s` = 0x1000+i. Required: `o_ready` = 0 through cycle 7, 1 in cycle 8. Then rd = 1 in cycle 8 gives `out_valid` = 1 in cycle 9 with column i = 0x1000+i and `o_ready` = 0.
- Fill and overflow: write 16 rows into all columns. Required: `o_full` = 1 and `o_overflow` = 0. A 17th write to column 3 only gives `o_overflow` = 1, and pop counts remain 16.
- Full with simultaneous push/pop: 16 rows stored, then rd = 1 and `valid` = all ones in the same cycle. Required: no overflow, `o_full` stays 1, and 16 subsequent pops return rows 2..17 in order.
- Zero flags: write a row with `in_s_zero` = 8'hA5 and `in_s` = all 0xFFFF. Required: after popping, `out_zero` = 8'hA5, columns 0,2,5,7 of `out` = 0, and the other columns = 0xFFFF.
- Pipelined flush with wrap: stream 40 skewed rows while issuing rd whenever `o_ready` is high. Required: 40 `out_valid` strobes, in-order data, pointers wrap twice, no overflow.
- Reset mid-flush: with 5 rows buffered and rd held high, assert `reset` asynchronously between edges. Required: `out_valid`, `o_ready` and `out` all go to 0 immediately, and no further strobes occur after reset deasserts.
